// File: rtl/hello_scroll_ctrl.sv
// Scroll sequencer for the eight-digit HEX bank: rotates the fixed "HELLO___" message
// by one slot per step, either on a prescaled timer (Run) or on a manual Step edge.
module hello_scroll_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Dir,
    input  logic        Step,
    output logic [23:0] CharBus,
    output logic [2:0]  Offset,
    output logic        Tick,
    output logic        state_dbg
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [2:0] CODE_H     = 3'b000;
    localparam logic [2:0] CODE_E     = 3'b001;
    localparam logic [2:0] CODE_L     = 3'b010;
    localparam logic [2:0] CODE_O     = 3'b011;
    localparam logic [2:0] CODE_BLANK = 3'b100;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       offset_q, offset_d;
    logic             tick_q, tick_d;
    logic             step_d_q, step_d_d;
    logic [23:0]      char_bus;

    logic advance_run;
    logic advance_step;
    logic advance;

    function automatic logic [2:0] msg_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = CODE_H;
            3'd1:    code = CODE_E;
            3'd2:    code = CODE_L;
            3'd3:    code = CODE_L;
            3'd4:    code = CODE_O;
            default: code = CODE_BLANK;
        endcase
        return code;
    endfunction

    // A Run change always wins over a terminal count or a Step edge on the same cycle.
    always_comb begin
        advance_run  = (state_q == ST_RUN) && Run && (cnt_q == CNT_LAST);
        advance_step = (state_q == ST_STOP) && !Run && Step && !step_d_q;
        advance      = advance_run || advance_step;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        tick_d   = advance;
        step_d_d = Step;

        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                if (Run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!Run) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
        endcase

        if (advance) begin
            offset_d = Dir ? (offset_q - 3'd1) : (offset_q + 3'd1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_STOP;
            cnt_q    <= '0;
            offset_q <= 3'd0;
            tick_q   <= 1'b0;
            step_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
            tick_q   <= tick_d;
            step_d_q <= step_d_d;
        end
    end

    // HEX7 (top field) shows the character at the current offset, HEX0 the one 7 slots on.
    always_comb begin
        char_bus = '0;
        for (int j = 0; j < 8; j++) begin
            char_bus[3*(7-j) +: 3] = msg_code(offset_q + 3'(j));
        end
    end

    assign CharBus   = char_bus;
    assign Offset    = offset_q;
    assign Tick      = tick_q;
    assign state_dbg = state_q;

endmodule
